tank_palette_ctrl: RTL and testbench

Run-time controller for the 16-entry, 12-bit sprite colour palette used by the tank sprites. After reset it loads the default palette into a writable palette store and serves one pixel-index lookup per cycle with a registered RGB result and a transparency flag. It accepts palette rewrites from game logic through a valid/ready port. It also applies a frame-counted "hit flash" that overrides opaque pixels with a flash colour. It sits between the sprite ROM index output and the VGA colour mux.

---
 rtl/tank_palette_pkg.sv | 18 +
 rtl/palette_ram16.sv | 29 ++
 rtl/tank_palette_ctrl.sv | 121 ++++++++++++
 tb/tb_tank_palette_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tank_palette_pkg.sv
// Shared types and the power-on palette for the tank sprite colour path.
// Latency: n/a (types/constants). Backpressure: n/a.
// Holds the 12-bit colour type, 4-bit index type, default palette and controller states.
package tank_palette_pkg;

  typedef logic [11:0] rgb12_t;
  typedef logic [3:0]  pal_idx_t;

  typedef enum logic {INIT, RUN} state_t;

  localparam rgb12_t DEFAULT_PALETTE [0:15] = '{
    12'hFF0, 12'hFFF, 12'hD53, 12'h221,
    12'hFA9, 12'hFA1, 12'hF61, 12'hA52,
    12'hFDD, 12'h821, 12'h443, 12'hE76,
    12'hE31, 12'hAAA, 12'hFD0, 12'hD83
  };

endpackage

// File: rtl/palette_ram16.sv
// 16x12 register file: one synchronous write port, one synchronous read port.
// Latency: 1 cycle read. Backpressure: none, accepts a read and a write every cycle.
// A read and write to the same entry on one edge returns the old contents.
module palette_ram16
  import tank_palette_pkg::*;
(
  input  logic     Clk,
  input  logic     Reset_n,
  input  logic     wr_en,
  input  pal_idx_t wr_addr,
  input  rgb12_t   wr_dat,
  input  logic     rd_en,
  input  pal_idx_t rd_addr,
  output rgb12_t   rd_dat
);

  rgb12_t mem [16];

  // Contents are rebuilt by the loader after every reset, so the array itself is not reset.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)   rd_dat <= '0;
    else if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/tank_palette_ctrl.sv
// Tank sprite palette: loads defaults after reset, then serves index->RGB lookups with hit flash.
// Latency: 1 cycle from pix_valid to rgb_valid. Backpressure: writes stalled (wr_ready=0) during load.
// Lookups are never stalled; requests during the load are dropped.
module tank_palette_ctrl
  import tank_palette_pkg::*;
#(
  parameter int unsigned FLASH_FRAMES = 8,
  parameter rgb12_t      FLASH_RGB    = 12'hFFF,
  parameter int unsigned KEY_INDEX    = 0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic       hit,
  input  logic       wr_req,
  input  logic [3:0] wr_index,
  input  logic [11:0] wr_rgb,
  output logic       wr_ready,
  input  logic       pix_valid,
  input  logic [3:0] pix_index,
  output logic       rgb_valid,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       transparent,
  output logic       busy,
  output logic       flashing
);

  // A zero-frame flash still needs a 1-bit counter so the logic stays well formed.
  localparam int unsigned FW         = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES);
  localparam pal_idx_t    KEY        = pal_idx_t'(KEY_INDEX);

  state_t          state_q, state_d;
  pal_idx_t        load_cnt_q;
  logic [FW-1:0]   flash_cnt_q;
  logic            ram_wr_vld;
  pal_idx_t        ram_wr_idx;
  rgb12_t          ram_wr_dat;
  rgb12_t          ram_rd_dat;
  logic            lookup_vld;
  logic            flash_sel_q;
  logic            transparent_q;
  logic            rgb_valid_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= INIT;
      load_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) load_cnt_q <= load_cnt_q + 4'd1;
    end
  end

  // The loader owns the RAM write port in INIT; game writes get it in RUN.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    wr_ready   = 1'b0;
    ram_wr_vld = 1'b0;
    ram_wr_idx = wr_index;
    ram_wr_dat = wr_rgb;
    case (state_q)
      INIT: begin
        busy       = 1'b1;
        ram_wr_vld = 1'b1;
        ram_wr_idx = load_cnt_q;
        ram_wr_dat = DEFAULT_PALETTE[load_cnt_q];
        if (load_cnt_q == 4'd15) state_d = RUN;
      end
      RUN: begin
        wr_ready   = 1'b1;
        ram_wr_vld = wr_req;
      end
      default: state_d = INIT;
    endcase
  end

  assign lookup_vld = pix_valid && (state_q == RUN);

  palette_ram16 u_ram (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .wr_en   (ram_wr_vld),
    .wr_addr (ram_wr_idx),
    .wr_dat  (ram_wr_dat),
    .rd_en   (lookup_vld),
    .rd_addr (pix_index),
    .rd_dat  (ram_rd_dat)
  );

  // A hit reload takes priority over a same-cycle frame decrement.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                               flash_cnt_q <= '0;
    else if (hit)                               flash_cnt_q <= FLASH_LOAD;
    else if (frame_start && flash_cnt_q != '0)  flash_cnt_q <= flash_cnt_q - 1'b1;
  end

  assign flashing = (flash_cnt_q != '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_valid_q   <= 1'b0;
      flash_sel_q   <= 1'b0;
      transparent_q <= 1'b0;
    end else begin
      rgb_valid_q <= lookup_vld;
      if (lookup_vld) begin
        flash_sel_q   <= flashing && (pix_index != KEY);
        transparent_q <= (pix_index == KEY);
      end
    end
  end

  assign rgb_valid          = rgb_valid_q;
  assign transparent        = transparent_q;
  assign {red, green, blue} = flash_sel_q ? FLASH_RGB : ram_rd_dat;

endmodule

// File: tb/tb_tank_palette_ctrl.sv
// Directed bench for tank_palette_ctrl: load timing, lookups, writes, flash and reset.
module tb_tank_palette_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start, hit, wr_req, pix_valid;
  logic [3:0]  wr_index, pix_index;
  logic [11:0] wr_rgb;
  logic        wr_ready, rgb_valid, transparent, busy, flashing;
  logic [3:0]  red, green, blue;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] pal [16] = '{
    12'hFF0, 12'hFFF, 12'hD53, 12'h221, 12'hFA9, 12'hFA1, 12'hF61, 12'hA52,
    12'hFDD, 12'h821, 12'h443, 12'hE76, 12'hE31, 12'hAAA, 12'hFD0, 12'hD83
  };

  tank_palette_ctrl #(
    .FLASH_FRAMES (8),
    .FLASH_RGB    (12'hFFF),
    .KEY_INDEX    (0)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .hit         (hit),
    .wr_req      (wr_req),
    .wr_index    (wr_index),
    .wr_rgb      (wr_rgb),
    .wr_ready    (wr_ready),
    .pix_valid   (pix_valid),
    .pix_index   (pix_index),
    .rgb_valid   (rgb_valid),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .transparent (transparent),
    .busy        (busy),
    .flashing    (flashing)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
    end
  endtask

  // Counts edges until busy drops; also watches that nothing leaks out during the load.
  task automatic wait_load(input string tag);
    int   n;
    logic wr_seen, rv_seen;
    n = 0;
    wr_seen = 1'b0;
    rv_seen = 1'b0;
    do begin
      step();
      n++;
      if (busy && wr_ready) wr_seen = 1'b1;
      if (rgb_valid)        rv_seen = 1'b1;
    end while (busy && n < 40);
    chk({tag, "_busy_cycles"}, 12'(n), 12'd16);
    chk1({tag, "_wr_ready_in_init"}, wr_seen, 1'b0);
    chk1({tag, "_rgb_valid_in_init"}, rv_seen, 1'b0);
    chk1({tag, "_wr_ready_after"}, wr_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n = 1'b0; frame_start = 1'b0; hit = 1'b0; wr_req = 1'b0;
    wr_index = '0; wr_rgb = '0; pix_valid = 1'b0; pix_index = '0;
    step();
    step();
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_wr_ready", wr_ready, 1'b0);
    chk1("rst_rgb_valid", rgb_valid, 1'b0);
    chk("rst_rgb", {red, green, blue}, 12'h000);
    chk1("rst_transparent", transparent, 1'b0);
    chk1("rst_flashing", flashing, 1'b0);

    // Write attempt and lookups during the load must be ignored.
    wr_req = 1'b1; wr_index = 4'd2; wr_rgb = 12'h123;
    pix_valid = 1'b1; pix_index = 4'd2;
    Reset_n = 1'b1;
    wait_load("load1");
    wr_req = 1'b0;
    chk1("first_lookup_not_yet_valid", rgb_valid, 1'b0);

    for (int i = 0; i < 16; i++) begin
      pix_index = 4'(i);
      step();
      chk1($sformatf("sweep%0d_valid", i), rgb_valid, 1'b1);
      chk($sformatf("sweep%0d_rgb", i), {red, green, blue}, pal[i]);
      chk1($sformatf("sweep%0d_transp", i), transparent, (i == 0));
    end

    pix_valid = 1'b0;
    step();
    chk1("idle_valid_low", rgb_valid, 1'b0);
    chk("idle_hold", {red, green, blue}, 12'hD83);

    // Same-cycle write and read of entry 5: old value first, new value next.
    wr_req = 1'b1; wr_index = 4'd5; wr_rgb = 12'h0F0;
    pix_valid = 1'b1; pix_index = 4'd5;
    chk1("run_wr_ready", wr_ready, 1'b1);
    step();
    wr_req = 1'b0;
    chk("rbw_old", {red, green, blue}, 12'hFA1);
    step();
    chk("rbw_new", {red, green, blue}, 12'h0F0);
    pix_valid = 1'b0;

    hit = 1'b1;
    step();
    hit = 1'b0;
    chk1("hit_flashing", flashing, 1'b1);
    pix_valid = 1'b1; pix_index = 4'd3;
    step();
    chk("flash_idx3", {red, green, blue}, 12'hFFF);
    chk1("flash_idx3_transp", transparent, 1'b0);
    pix_index = 4'd0;
    step();
    chk("flash_idx0_keeps_palette", {red, green, blue}, 12'hFF0);
    chk1("flash_idx0_transp", transparent, 1'b1);
    pix_valid = 1'b0;
    frames(7);
    chk1("flash_after7", flashing, 1'b1);
    frames(1);
    chk1("flash_after8", flashing, 1'b0);
    pix_valid = 1'b1; pix_index = 4'd3;
    step();
    chk("noflash_idx3", {red, green, blue}, 12'h221);
    pix_valid = 1'b0;

    // Retrigger with one frame left, coinciding with a frame pulse.
    hit = 1'b1;
    step();
    hit = 1'b0;
    frames(7);
    chk1("retrig_one_left", flashing, 1'b1);
    hit = 1'b1; frame_start = 1'b1;
    step();
    hit = 1'b0; frame_start = 1'b0;
    frames(7);
    chk1("retrig_after7", flashing, 1'b1);
    frames(1);
    chk1("retrig_after8", flashing, 1'b0);

    // Overwrite entry 1, start a flash, then reset mid-run.
    wr_req = 1'b1; wr_index = 4'd1; wr_rgb = 12'h000;
    step();
    wr_req = 1'b0;
    pix_valid = 1'b1; pix_index = 4'd1;
    step();
    chk("idx1_written", {red, green, blue}, 12'h000);
    pix_valid = 1'b0;
    hit = 1'b1;
    step();
    hit = 1'b0;
    chk1("pre_rst_flashing", flashing, 1'b1);
    Reset_n = 1'b0;
    #2;
    chk1("midrst_busy", busy, 1'b1);
    chk1("midrst_rgb_valid", rgb_valid, 1'b0);
    chk1("midrst_wr_ready", wr_ready, 1'b0);
    chk1("midrst_flashing", flashing, 1'b0);
    step();
    Reset_n = 1'b1;
    wait_load("load2");
    pix_valid = 1'b1; pix_index = 4'd1;
    step();
    chk("idx1_restored", {red, green, blue}, 12'hFFF);
    chk1("idx1_restored_valid", rgb_valid, 1'b1);
    pix_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
